// File: rtl/qam16_demap_decode_if.sv
// Symbol-sample input and decoded-code output bundle for qam16_demap_decode.
// master drives samples and clr; slave is the decoder.
interface qam16_demap_decode_if #(
    parameter int W = 3
);
    logic                din_valid;
    logic signed [W-1:0] di;
    logic signed [W-1:0] dq;
    logic                clr;
    logic [3:0]          dout;
    logic                dout_valid;

    modport master (output din_valid, di, dq, clr, input dout, dout_valid);
    modport slave  (input din_valid, di, dq, clr, output dout, dout_valid);
endinterface

// File: rtl/qam16_demap_decode.sv
// Purpose: 16QAM slicer + differential quadrant decoder, recovers {d3,d2,b1,b0}; QAM_SYMCNT_EN adds sym_cnt.
// Latency: 2 clk from din_valid to dout_valid, one symbol per clk.
// Backpressure: none, strobe in / strobe out; clr discards the symbol in stage 1.
module qam16_demap_decode #(
    parameter int W   = 3,
    parameter int THR = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    qam16_demap_decode_if.slave  bus
`ifdef QAM_SYMCNT_EN
    ,
    output logic [15:0]          sym_cnt
`endif
);

    localparam logic signed [W:0] THR_X = (W+1)'(THR);

    // One extra bit so -2^(W-1) has a representable magnitude and slices as outer.
    logic signed [W:0] di_x, dq_x, di_mag, dq_mag;
    logic              c_s, d_s, is_s, qs_s, b1_s, b0_s;

    assign di_x   = {bus.di[W-1], bus.di};
    assign dq_x   = {bus.dq[W-1], bus.dq};
    assign di_mag = di_x[W] ? -di_x : di_x;
    assign dq_mag = dq_x[W] ? -dq_x : dq_x;
    assign is_s   = (di_mag < THR_X);
    assign qs_s   = (dq_mag < THR_X);
    assign c_s    = bus.dq[W-1];
    assign d_s    = bus.di[W-1];
    assign b1_s   = (c_s == d_s) ? qs_s : is_s;
    assign b0_s   = (c_s == d_s) ? is_s : qs_s;

    logic       v1, c1, d1;
    logic [1:0] amp1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1   <= 1'b0;
            c1   <= 1'b0;
            d1   <= 1'b0;
            amp1 <= 2'b00;
        end else begin
            v1 <= bus.din_valid;
            if (bus.din_valid) begin
                c1   <= c_s;
                d1   <= d_s;
                amp1 <= {b1_s, b0_s};
            end
        end
    end

    logic [1:0] pref;
    logic [1:0] d32;

    always_comb begin
        d32 = 2'b00;
        case ({pref, c1, d1})
            4'b00_00: d32 = 2'b00;
            4'b00_01: d32 = 2'b01;
            4'b00_10: d32 = 2'b10;
            4'b00_11: d32 = 2'b11;
            4'b01_00: d32 = 2'b01;
            4'b01_01: d32 = 2'b11;
            4'b01_10: d32 = 2'b00;
            4'b01_11: d32 = 2'b10;
            4'b10_00: d32 = 2'b10;
            4'b10_01: d32 = 2'b00;
            4'b10_10: d32 = 2'b11;
            4'b10_11: d32 = 2'b01;
            4'b11_00: d32 = 2'b11;
            4'b11_01: d32 = 2'b10;
            4'b11_10: d32 = 2'b01;
            4'b11_11: d32 = 2'b00;
            default:  d32 = 2'b00;
        endcase
    end

    logic [3:0] dout_r;
    logic       dout_valid_r;

    // clr suppresses whatever sits in stage 1; a sample captured alongside clr decodes next cycle against 00.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pref         <= 2'b00;
            dout_r       <= 4'b0000;
            dout_valid_r <= 1'b0;
        end else if (bus.clr) begin
            pref         <= 2'b00;
            dout_valid_r <= 1'b0;
        end else if (v1) begin
            dout_r       <= {d32, amp1};
            pref         <= {c1, d1};
            dout_valid_r <= 1'b1;
        end else begin
            dout_valid_r <= 1'b0;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;

`ifdef QAM_SYMCNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 16'h0000;
        end else if (bus.clr) begin
            cnt <= 16'h0000;
        end else if (dout_valid_r && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign sym_cnt = cnt;
`endif

endmodule

// File: tb/tb_qam16_demap_decode.sv
// Directed bench for qam16_demap_decode: fixed vectors, clr/reset cases, encoder loopback and 180-degree rotation.
module tb_qam16_demap_decode;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nchk  = 0;
    int   npass = 0;
    int   nfail = 0;

    qam16_demap_decode_if #(.W(3)) bus ();

`ifdef QAM_SYMCNT_EN
    logic [15:0] sym_cnt;
    qam16_demap_decode #(.W(3), .THR(2)) dut (.clk(clk), .rst(rst), .bus(bus), .sym_cnt(sym_cnt));
`else
    qam16_demap_decode #(.W(3), .THR(2)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] i, input logic [2:0] q, input logic c);
        bus.din_valid = v;
        bus.di        = i;
        bus.dq        = q;
        bus.clr       = c;
    endtask

    // Quadrant index around the circle: cd 00,01,11,10 -> 0,1,2,3.
    function automatic int qi(input logic [1:0] x);
        case (x)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gc(input int k);
        case (k % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [2:0] lvl(input logic neg, input logic inner);
        if (neg) return inner ? 3'b111 : 3'b101;
        else     return inner ? 3'b001 : 3'b011;
    endfunction

    // Encoder model feeding the DUT; expects the DUT reference at 00 on entry.
    task automatic run_stream(input int n, input bit rot180, input string tag);
        logic [1:0] pe, cd, cdt;
        logic [3:0] s, e;
        logic       isb, qsb;
        logic [1:0] vp;
        logic [3:0] q[$];
        int         sent, got, cyc;
        pe = 2'b00; vp = 2'b00; sent = 0; got = 0; cyc = 0;
        while ((got < n) && (cyc < 5 * n + 20)) begin
            if ((sent < n) && ($urandom_range(0, 3) != 0)) begin
                s   = 4'($urandom_range(0, 15));
                cd  = gc(qi(s[3:2]) - qi(pe) + 4);
                pe  = cd;
                qsb = (cd[1] == cd[0]) ? s[1] : s[0];
                isb = (cd[1] == cd[0]) ? s[0] : s[1];
                cdt = rot180 ? ~cd : cd;
                e   = (rot180 && sent == 0) ? {gc(qi(s[3:2]) + 2), s[1:0]} : s;
                q.push_back(e);
                drive(1'b1, lvl(cdt[0], isb), lvl(cdt[1], qsb), 1'b0);
                sent++;
            end else begin
                drive(1'b0, 3'b000, 3'b000, 1'b0);
            end
            step();
            cyc++;
            vp = {vp[0], bus.din_valid};
            check({tag, "_valid"}, {15'd0, bus.dout_valid}, {15'd0, vp[1]});
            if (vp[1]) begin
                if (q.size() == 0) begin
                    check({tag, "_underflow"}, 16'd1, 16'd0);
                end else begin
                    e = q.pop_front();
                    check({tag, "_dout"}, {12'd0, bus.dout}, {12'd0, e});
                end
                got++;
            end
        end
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        check({tag, "_count"}, 16'(got), 16'(n));
    endtask

    initial begin
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        rst = 1'b0;
        step(); step();
        check("reset_dout", {12'd0, bus.dout}, 16'h0000);
        check("reset_valid", {15'd0, bus.dout_valid}, 16'h0000);
`ifdef QAM_SYMCNT_EN
        check("reset_symcnt", sym_cnt, 16'h0000);
`endif
        rst = 1'b1;
        step();

        // Single outer symbol in the first quadrant.
        drive(1'b1, 3'b011, 3'b011, 1'b0); step();
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        check("lat1_valid", {15'd0, bus.dout_valid}, 16'h0000);
        step();
        check("lat2_valid", {15'd0, bus.dout_valid}, 16'h0001);
        check("lat2_dout", {12'd0, bus.dout}, 16'h0000);
        step();
        check("lat3_valid", {15'd0, bus.dout_valid}, 16'h0000);

        rst = 1'b0; step(); rst = 1'b1; step();

        // Back-to-back pair, then the -4 extreme sample.
        drive(1'b1, 3'b111, 3'b101, 1'b0); step();
        drive(1'b1, 3'b101, 3'b101, 1'b0); step();
        check("pair0_valid", {15'd0, bus.dout_valid}, 16'h0001);
        check("pair0_dout", {12'd0, bus.dout}, 16'h000D);
        drive(1'b1, 3'b100, 3'b001, 1'b0); step();
        check("pair1_valid", {15'd0, bus.dout_valid}, 16'h0001);
        check("pair1_dout", {12'd0, bus.dout}, 16'h0000);
        drive(1'b0, 3'b000, 3'b000, 1'b0); step();
        check("ext_valid", {15'd0, bus.dout_valid}, 16'h0001);
        check("ext_dout", {12'd0, bus.dout}, 16'h0009);
        step();
        check("hold_valid", {15'd0, bus.dout_valid}, 16'h0000);
        check("hold_dout", {12'd0, bus.dout}, 16'h0009);

        // clr with concurrent din_valid: A (cd=10) is dropped, B decodes against 00.
        drive(1'b1, 3'b011, 3'b111, 1'b0); step();
        drive(1'b1, 3'b111, 3'b001, 1'b1); step();
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        check("clr_drop_valid", {15'd0, bus.dout_valid}, 16'h0000);
        step();
        check("clr_b_valid", {15'd0, bus.dout_valid}, 16'h0001);
        check("clr_b_dout", {12'd0, bus.dout}, 16'h0007);

        // Reset while a symbol is in flight.
        drive(1'b1, 3'b111, 3'b101, 1'b0); step();
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        rst = 1'b0;
        #2;
        check("rstmid_dout", {12'd0, bus.dout}, 16'h0000);
        check("rstmid_valid", {15'd0, bus.dout_valid}, 16'h0000);
        #1 rst = 1'b1;
        step(); step();
        check("rstmid_flush", {15'd0, bus.dout_valid}, 16'h0000);
        drive(1'b1, 3'b111, 3'b101, 1'b0); step();
        drive(1'b0, 3'b000, 3'b000, 1'b0); step();
        check("rstmid_ref_valid", {15'd0, bus.dout_valid}, 16'h0001);
        check("rstmid_ref_dout", {12'd0, bus.dout}, 16'h000D);

        drive(1'b0, 3'b000, 3'b000, 1'b1); step();
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        run_stream(1000, 1'b0, "loop");

        drive(1'b0, 3'b000, 3'b000, 1'b1); step();
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        run_stream(300, 1'b1, "rot180");

`ifdef QAM_SYMCNT_EN
        step(); step();
        drive(1'b0, 3'b000, 3'b000, 1'b1); step();
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        check("symcnt_clr", sym_cnt, 16'h0000);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'b011, 3'b011, 1'b0); step();
        end
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        step(); step(); step();
        check("symcnt_three", sym_cnt, 16'h0003);
        for (int k = 0; k < 65540; k++) begin
            drive(1'b1, 3'b011, 3'b011, 1'b0); step();
        end
        drive(1'b0, 3'b000, 3'b000, 1'b0);
        step(); step(); step();
        check("symcnt_sat", sym_cnt, 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
